// File: rtl/sdram_frame_sched_if.sv
// sdram_frame_sched_if: burst request/ack handshake and start addresses between scheduler and SDRAM controller
interface sdram_frame_sched_if #(parameter int ADDR_W = 24);
  logic              wr_req;
  logic              wr_ack;
  logic              rd_req;
  logic              rd_ack;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  modport master (output wr_req, rd_req, wr_addr, rd_addr, input wr_ack, rd_ack);
  modport slave  (input wr_req, rd_req, wr_addr, rd_addr, output wr_ack, rd_ack);
endinterface

// File: rtl/sdram_frame_sched.sv
// sdram_frame_sched: ping-pong frame buffer burst scheduler arbitrating camera writes and display reads
module sdram_frame_sched #(
  parameter int ADDR_W    = 24,
  parameter int ROW_LSB   = 9,
  parameter int BURSTS    = 128,
  parameter int BUF_BIT   = 21,
  parameter int CNT_W     = 11,
  parameter int WR_THRESH = 512,
  parameter int RD_THRESH = 512,
  parameter int PRIO_MODE = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_frame_start_i,
  input  logic                rd_frame_start_i,
  input  logic                rd_enable_i,
  input  logic [CNT_W-1:0]    wr_fifo_used_i,
  input  logic [CNT_W-1:0]    rd_fifo_used_i,
  sdram_frame_sched_if.master bus,
  output logic                frame_valid_o,
  output logic                err_wr_short_o,
  output logic                err_rd_short_o
);
  localparam int CW = $clog2(BURSTS + 1);
  localparam logic [CW-1:0] LAST = CW'(BURSTS);
  typedef enum logic [1:0] {IDLE, WR_BUSY, RD_BUSY} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d, wr_done, rd_done;
  logic          wr_buf_q, wr_buf_d, rd_buf_q, rd_buf_d, ready_buf_q, ready_buf_d;
  logic          frame_valid_q, frame_valid_d, err_wr_q, err_wr_d, err_rd_q, err_rd_d;
  logic          pref_rd_q, pref_rd_d, wr_pend_q, wr_pend_d, rd_pend_q, rd_pend_d;
  logic          wr_fin, rd_fin, wr_hold, rd_hold, wr_go, rd_go, wr_el, rd_el, wr_mid, grant_rd;
  // burst completion, deferred frame starts, buffer swap and error bookkeeping
  always_comb begin
    wr_fin        = state_q == WR_BUSY && bus.wr_ack;
    rd_fin        = state_q == RD_BUSY && bus.rd_ack;
    wr_hold       = state_q == WR_BUSY && !bus.wr_ack;
    rd_hold       = state_q == RD_BUSY && !bus.rd_ack;
    wr_done       = wr_cnt_q + CW'(wr_fin && wr_cnt_q < LAST);
    rd_done       = rd_cnt_q + CW'(rd_fin && rd_cnt_q < LAST);
    wr_go         = (wr_frame_start_i || wr_pend_q) && !wr_hold;
    rd_go         = (rd_frame_start_i || rd_pend_q) && !rd_hold;
    wr_pend_d     = (wr_frame_start_i || wr_pend_q) && wr_hold;
    rd_pend_d     = (rd_frame_start_i || rd_pend_q) && rd_hold;
    wr_mid        = wr_cnt_q != '0 && wr_cnt_q < LAST;
    rd_buf_d      = rd_go && !(wr_mid && wr_buf_q == ready_buf_q) ? ready_buf_q : rd_buf_q;
    rd_cnt_d      = rd_go ? '0 : rd_done;
    err_rd_d      = err_rd_q || (rd_go && rd_done != '0 && rd_done < LAST);
    wr_buf_d      = wr_go ? !rd_buf_d : wr_buf_q;
    wr_cnt_d      = wr_go ? '0 : wr_done;
    err_wr_d      = err_wr_q || (wr_go && wr_done != '0 && wr_done < LAST);
    ready_buf_d   = wr_fin && wr_done == LAST ? wr_buf_q : ready_buf_q;
    frame_valid_d = frame_valid_q || (wr_fin && wr_done == LAST);
  end
  // arbitration: grant one eligible side from IDLE, return to IDLE on its ack
  always_comb begin
    wr_el     = wr_cnt_q < LAST && wr_fifo_used_i >= CNT_W'(WR_THRESH);
    rd_el     = rd_enable_i && frame_valid_q && rd_cnt_q < LAST && rd_fifo_used_i <= CNT_W'(RD_THRESH);
    grant_rd  = rd_el && (!wr_el || (PRIO_MODE != 0 && pref_rd_q));
    state_d   = state_q;
    pref_rd_d = pref_rd_q;
    if (state_q == IDLE && (wr_el || rd_el)) begin
      state_d   = grant_rd ? RD_BUSY : WR_BUSY;
      pref_rd_d = !grant_rd;
    end else if (wr_fin || rd_fin) begin
      state_d = IDLE;
    end
  end
  // state and bookkeeping registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      wr_cnt_q      <= '0;
      rd_cnt_q      <= '0;
      wr_buf_q      <= 1'b0;
      rd_buf_q      <= 1'b0;
      ready_buf_q   <= 1'b0;
      frame_valid_q <= 1'b0;
      err_wr_q      <= 1'b0;
      err_rd_q      <= 1'b0;
      pref_rd_q     <= 1'b0;
      wr_pend_q     <= 1'b0;
      rd_pend_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_cnt_q      <= wr_cnt_d;
      rd_cnt_q      <= rd_cnt_d;
      wr_buf_q      <= wr_buf_d;
      rd_buf_q      <= rd_buf_d;
      ready_buf_q   <= ready_buf_d;
      frame_valid_q <= frame_valid_d;
      err_wr_q      <= err_wr_d;
      err_rd_q      <= err_rd_d;
      pref_rd_q     <= pref_rd_d;
      wr_pend_q     <= wr_pend_d;
      rd_pend_q     <= rd_pend_d;
    end
  end
  // burst start addresses: buffer select bit over burst index, held while the counters are frozen in BUSY
  always_comb begin
    bus.wr_addr          = ADDR_W'(wr_cnt_q) << ROW_LSB;
    bus.wr_addr[BUF_BIT] = wr_buf_q;
    bus.rd_addr          = ADDR_W'(rd_cnt_q) << ROW_LSB;
    bus.rd_addr[BUF_BIT] = rd_buf_q;
  end
  assign bus.wr_req     = state_q == WR_BUSY;
  assign bus.rd_req     = state_q == RD_BUSY;
  assign frame_valid_o  = frame_valid_q;
  assign err_wr_short_o = err_wr_q;
  assign err_rd_short_o = err_rd_q;
endmodule

// File: tb/tb_sdram_frame_sched.sv
// tb_sdram_frame_sched: vectors, corner sequences and randomized model check for both priority modes
module tb_sdram_frame_sched;
  localparam int NB  = 4;
  localparam int LAT = 3;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_fs = 1'b0, rd_fs = 1'b0, rd_en = 1'b0;
  logic [10:0] wr_used = '0, rd_used = '0;
  logic [1:0]  fv, ew, er;
  int          tests = 0, fails = 0;
  bit          auto_ack = 1'b1;
  int          rc[4];
  int m_busy[2], m_wc[2], m_rc[2], m_wb[2], m_rb[2], m_ready[2];
  int m_fv[2], m_ew[2], m_er[2], m_lastw[2], m_wp[2], m_rp[2];
  typedef struct {
    logic [10:0] wu;
    logic        re;
    logic [10:0] ru;
    logic [1:0]  exp;
  } vec_t;
  vec_t tbl[5];

  sdram_frame_sched_if #(.ADDR_W(24)) bus0();
  sdram_frame_sched_if #(.ADDR_W(24)) bus1();

  sdram_frame_sched #(.BURSTS(NB), .PRIO_MODE(0)) u0 (
    .clk(clk), .rst_n(rst_n), .wr_frame_start_i(wr_fs), .rd_frame_start_i(rd_fs),
    .rd_enable_i(rd_en), .wr_fifo_used_i(wr_used), .rd_fifo_used_i(rd_used), .bus(bus0),
    .frame_valid_o(fv[0]), .err_wr_short_o(ew[0]), .err_rd_short_o(er[0]));

  sdram_frame_sched #(.BURSTS(NB), .PRIO_MODE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .wr_frame_start_i(wr_fs), .rd_frame_start_i(rd_fs),
    .rd_enable_i(rd_en), .wr_fifo_used_i(wr_used), .rd_fifo_used_i(rd_used), .bus(bus1),
    .frame_valid_o(fv[1]), .err_wr_short_o(ew[1]), .err_rd_short_o(er[1]));

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic resp(input logic req, input logic ack_i, output logic ack_o, inout int c);
    ack_o = 1'b0;
    if (ack_i) c = 0;
    else if (req) begin
      c++;
      if (c == LAT) begin
        ack_o = 1'b1;
        c = 0;
      end
    end else c = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    if (auto_ack) begin
      resp(bus0.wr_req, bus0.wr_ack, bus0.wr_ack, rc[0]);
      resp(bus0.rd_req, bus0.rd_ack, bus0.rd_ack, rc[1]);
      resp(bus1.wr_req, bus1.wr_ack, bus1.wr_ack, rc[2]);
      resp(bus1.rd_req, bus1.rd_ack, bus1.rd_ack, rc[3]);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    {wr_fs, rd_fs, rd_en} = '0;
    wr_used = '0;
    rd_used = '0;
    {bus0.wr_ack, bus0.rd_ack, bus1.wr_ack, bus1.rd_ack} = '0;
    for (int i = 0; i < 4; i++) rc[i] = 0;
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic wait_req(input bit rd, input logic lvl, input string name);
    int n = 0;
    while (n < 40 && (rd ? bus1.rd_req : bus1.wr_req) !== lvl) begin
      cyc();
      n++;
    end
    check(name, rd ? bus1.rd_req : bus1.wr_req, lvl);
  endtask

  function automatic logic [52:0] outs(input int p);
    return p == 1 ? {bus1.wr_req, bus1.rd_req, bus1.wr_addr, bus1.rd_addr, fv[1], ew[1], er[1]}
                  : {bus0.wr_req, bus0.rd_req, bus0.wr_addr, bus0.rd_addr, fv[0], ew[0], er[0]};
  endfunction

  task automatic m_reset();
    for (int p = 0; p < 2; p++) begin
      m_busy[p] = 0; m_wc[p] = 0; m_rc[p] = 0; m_wb[p] = 0; m_rb[p] = 0; m_ready[p] = 0;
      m_fv[p] = 0; m_ew[p] = 0; m_er[p] = 0; m_lastw[p] = 0; m_wp[p] = 0; m_rp[p] = 0;
    end
  endtask

  // one clock edge of the scheduler, described in terms of bursts, frames and buffers
  task automatic model_step(input int p, input bit wack, input bit rack);
    bit wfin   = m_busy[p] == 1 && wack;
    bit rfin   = m_busy[p] == 2 && rack;
    int wdone  = m_wc[p] + int'(wfin);
    int rdone  = m_rc[p] + int'(rfin);
    bit wstart = wr_fs || m_wp[p] != 0;
    bit rstart = rd_fs || m_rp[p] != 0;
    bit we     = m_wc[p] < NB && wr_used >= 512;
    bit re     = rd_en && m_fv[p] != 0 && m_rc[p] < NB && rd_used <= 512;
    m_wp[p] = 0;
    m_rp[p] = 0;
    if (m_busy[p] == 1 && !wack) begin m_wp[p] = int'(wstart); wstart = 0; end
    if (m_busy[p] == 2 && !rack) begin m_rp[p] = int'(rstart); rstart = 0; end
    if (m_busy[p] == 0) begin
      if (we && re) m_busy[p] = (p == 1 && m_lastw[p] != 0) ? 2 : 1;
      else m_busy[p] = we ? 1 : re ? 2 : 0;
      if (m_busy[p] != 0) m_lastw[p] = int'(m_busy[p] == 1);
    end else if (wfin || rfin) m_busy[p] = 0;
    if (rstart) begin
      if (rdone > 0 && rdone < NB) m_er[p] = 1;
      if (!(m_wc[p] > 0 && m_wc[p] < NB && m_wb[p] == m_ready[p])) m_rb[p] = m_ready[p];
      m_rc[p] = 0;
    end else m_rc[p] = rdone;
    if (wfin && wdone == NB) begin
      m_ready[p] = m_wb[p];
      m_fv[p] = 1;
    end
    if (wstart) begin
      if (wdone > 0 && wdone < NB) m_ew[p] = 1;
      m_wb[p] = 1 - m_rb[p];
      m_wc[p] = 0;
    end else m_wc[p] = wdone;
  endtask

  function automatic logic [52:0] m_out(input int p);
    logic [23:0] wa = 24'(m_wb[p] * 2097152 + m_wc[p] * 512);
    logic [23:0] ra = 24'(m_rb[p] * 2097152 + m_rc[p] * 512);
    return {m_busy[p] == 1, m_busy[p] == 2, wa, ra, m_fv[p] != 0, m_ew[p] != 0, m_er[p] != 0};
  endfunction

  initial begin
    logic [3:0] seq0, seq1;
    int n0, n1, hi, n;
    logic pw0, pr0, pw1, pr1;
    tbl[0] = '{11'd512,  1'b1, 11'd0,   2'b10};
    tbl[1] = '{11'd511,  1'b1, 11'd0,   2'b00};
    tbl[2] = '{11'd2047, 1'b1, 11'd0,   2'b10};
    tbl[3] = '{11'd0,    1'b1, 11'd0,   2'b00};
    tbl[4] = '{11'd511,  1'b0, 11'd512, 2'b00};

    do_reset();
    check("reset_outs_p1", 64'(outs(1)), 64'd0);
    check("reset_outs_p0", 64'(outs(0)), 64'd0);

    for (int i = 0; i < 5; i++) begin
      do_reset();
      wr_used = tbl[i].wu;
      rd_en   = tbl[i].re;
      rd_used = tbl[i].ru;
      cyc();
      cyc();
      check($sformatf("elig_vec%0d", i), 64'({bus1.wr_req, bus1.rd_req}), 64'(tbl[i].exp));
    end

    do_reset();
    wr_used = 11'd512;
    for (int b = 0; b < NB; b++) begin
      wait_req(0, 1'b1, "wr_req_rise");
      check($sformatf("wr_addr_burst%0d", b), 64'(bus1.wr_addr), 64'(b * 'h200));
      wait_req(0, 1'b0, "wr_req_fall");
    end
    check("frame_valid_set", 64'(fv[1]), 64'd1);
    hi = 0;
    repeat (20) begin
      cyc();
      hi += int'(bus1.wr_req);
    end
    check("no_fifth_wr_req", 64'(hi), 64'd0);
    rd_fs = 1'b1;
    cyc();
    rd_fs = 1'b0;
    wr_fs = 1'b1;
    cyc();
    wr_fs = 1'b0;
    check("swap_rd_addr", 64'(bus1.rd_addr), 64'h000000);
    check("swap_wr_addr", 64'(bus1.wr_addr), 64'h200000);

    do_reset();
    wr_used = 11'd512;
    wait_req(0, 1'b1, "short_b0_rise");
    wait_req(0, 1'b0, "short_b0_fall");
    wait_req(0, 1'b1, "short_b1_rise");
    wr_fs = 1'b1;
    cyc();
    wr_fs = 1'b0;
    check("start_in_busy_addr_held", 64'(bus1.wr_addr), 64'h200);
    check("start_in_busy_no_err_yet", 64'(ew[1]), 64'd0);
    wait_req(0, 1'b0, "short_b1_fall");
    check("err_wr_short", 64'(ew[1]), 64'd1);
    check("restart_wr_addr", 64'(bus1.wr_addr), 64'h200000);
    wait_req(0, 1'b1, "restart_rise");
    check("restart_burst0_addr", 64'(bus1.wr_addr), 64'h200000);
    check("no_err_rd_short", 64'(er[1]), 64'd0);

    do_reset();
    wr_used = 11'd512;
    wait_req(0, 1'b1, "abort_b0_rise");
    wait_req(0, 1'b0, "abort_b0_fall");
    wait_req(0, 1'b1, "abort_b1_rise");
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_wr_req", 64'(bus1.wr_req), 64'd0);
    check("abort_outs", 64'(outs(1)), 64'd0);

    do_reset();
    wr_used = 11'd512;
    n = 0;
    while (n < 200 && fv !== 2'b11) begin
      cyc();
      n++;
    end
    check("prio_frame_valid_both", 64'(fv), 64'd3);
    rd_fs = 1'b1;
    wr_fs = 1'b1;
    cyc();
    {rd_fs, wr_fs} = '0;
    rd_en = 1'b1;
    rd_used = 11'd0;
    {seq0, seq1, n0, n1, pw0, pr0, pw1, pr1} = '0;
    n = 0;
    while (n < 300 && (n0 < 4 || n1 < 4)) begin
      cyc();
      n++;
      if (n0 < 4 && bus0.wr_req && !pw0) begin seq0 = {seq0[2:0], 1'b1}; n0++; end
      if (n0 < 4 && bus0.rd_req && !pr0) begin seq0 = {seq0[2:0], 1'b0}; n0++; end
      if (n1 < 4 && bus1.wr_req && !pw1) begin seq1 = {seq1[2:0], 1'b1}; n1++; end
      if (n1 < 4 && bus1.rd_req && !pr1) begin seq1 = {seq1[2:0], 1'b0}; n1++; end
      {pw0, pr0, pw1, pr1} = {bus0.wr_req, bus0.rd_req, bus1.wr_req, bus1.rd_req};
    end
    check("grants_fixed_prio", 64'(seq0), 64'b1111);
    check("grants_round_robin", 64'(seq1), 64'b0101);

    auto_ack = 1'b0;
    for (int r = 0; r < 2; r++) begin
      do_reset();
      m_reset();
      for (int c = 0; c < 1500; c++) begin
        wr_used     = 11'($urandom_range(470, 560));
        rd_used     = 11'($urandom_range(470, 560));
        rd_en       = $urandom_range(0, 7) != 0;
        wr_fs       = $urandom_range(0, 59) == 0;
        rd_fs       = $urandom_range(0, 49) == 0;
        bus0.wr_ack = $urandom_range(0, 2) == 0;
        bus0.rd_ack = $urandom_range(0, 2) == 0;
        bus1.wr_ack = $urandom_range(0, 2) == 0;
        bus1.rd_ack = $urandom_range(0, 2) == 0;
        model_step(0, bus0.wr_ack, bus0.rd_ack);
        model_step(1, bus1.wr_ack, bus1.rd_ack);
        cyc();
        check($sformatf("rand_prio0_c%0d", c), 64'(outs(0)), 64'(m_out(0)));
        check($sformatf("rand_prio1_c%0d", c), 64'(outs(1)), 64'(m_out(1)));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
